dcache_responder: RTL and testbench

Memory-side responder for the pipeline's data-memory requests: it receives the store/load controls the controller emits (write enable, store size, load size) and answers them. It is a direct-mapped, one-word-per-line, write-through, no-write-allocate data cache. A handshake to backing memory services misses and write-throughs, and the block stalls the pipeline while busy. It sits between the X/M stage datapath and the memory arbiter.

---
 rtl/dcache_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dcache_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, one-word-per-line, write-through, no-write-allocate data cache.
// Define DCACHE_STATS_EN to add the hit_count/miss_count load counters.
module dcache_responder #(
  parameter int LINES = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [1:0]    req_st_size,
  input  logic [2:0]    req_ld_size,
  output logic          stall,
  output logic          resp_valid,
  output logic [31:0]   resp_data,
  output logic          misalign,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_req_addr,
  output logic [31:0]   mem_req_wdata,
  output logic [3:0]    mem_req_mask,
  input  logic          mem_resp_valid,
  input  logic [31:0]   mem_resp_data,
`ifdef DCACHE_STATS_EN
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count,
`endif
  output logic [1:0]    dbg_state
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = AW - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_REQ  = 2'd2,
    READ_WAIT = 2'd3
  } state_t;

  // Handshake: mem_req_valid stays high with we/addr/wdata/mask stable until a cycle
  // in which mem_req_ready is also high; that cycle is the transfer.
  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [2:0]        ld_size_q, ld_size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              misalign_q, misalign_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [31:0]       data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];

  logic              arr_we;
  logic [IDX_W-1:0]  arr_idx;
  logic [TAG_W-1:0]  arr_tag;
  logic [31:0]       arr_data;

  logic [IDX_W-1:0]  idx_in;
  logic [TAG_W-1:0]  tag_in;
  logic              hit;
  logic [1:0]        width;
  logic              misaligned;
  logic [3:0]        st_mask;
  logic [31:0]       st_wdata;

  // Width code: 0 byte, 1 half, 2 word.
  function automatic logic [1:0] ld_width(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: ld_width = 2'd0;
      3'd1, 3'd5: ld_width = 2'd1;
      default:    ld_width = 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] f);
    logic [31:0] bw;
    logic [31:0] hw;
    bw = w >> {a, 3'b000};
    hw = w >> {a[1], 4'b0000};
    case (f)
      3'd0:    extract = {{24{bw[7]}}, bw[7:0]};
      3'd1:    extract = {{16{hw[15]}}, hw[15:0]};
      3'd4:    extract = {24'b0, bw[7:0]};
      3'd5:    extract = {16'b0, hw[15:0]};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    idx_in     = req_addr[IDX_W+1:2];
    tag_in     = req_addr[AW-1:IDX_W+2];
    hit        = valid_q[idx_in] && (tag_q[idx_in] == tag_in);
    width      = req_we ? ((req_st_size == 2'd0) ? 2'd0 :
                           (req_st_size == 2'd1) ? 2'd1 : 2'd2)
                        : ld_width(req_ld_size);
    misaligned = ((width == 2'd1) && req_addr[0]) ||
                 ((width == 2'd2) && (req_addr[1:0] != 2'b00));
    case (req_st_size)
      2'd0: begin
        st_mask  = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        st_mask  = 4'b0011 << {req_addr[1], 1'b0};
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_mask  = 4'hF;
        st_wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ld_size_d    = ld_size_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    resp_valid_d = 1'b0;
    resp_data_d  = 32'h0;
    misalign_d   = 1'b0;
    valid_d      = valid_q;
    arr_we       = 1'b0;
    arr_idx      = idx_in;
    arr_tag      = tag_in;
    arr_data     = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            misalign_d   = 1'b1;
            resp_valid_d = !req_we;
          end else if (req_we) begin
            addr_d  = req_addr;
            mask_d  = st_mask;
            wdata_d = st_wdata;
            state_d = WRITE;
            if (hit) begin
              arr_we   = 1'b1;
              arr_data = merge(data_q[idx_in], st_wdata, st_mask);
            end
          end else if (hit) begin
            resp_valid_d = 1'b1;
            resp_data_d  = extract(data_q[idx_in], req_addr[1:0], req_ld_size);
          end else begin
            addr_d    = req_addr;
            ld_size_d = req_ld_size;
            state_d   = READ_REQ;
          end
        end
      end
      WRITE: begin
        if (mem_req_ready) state_d = IDLE;
      end
      READ_REQ: begin
        if (mem_req_ready) state_d = READ_WAIT;
      end
      READ_WAIT: begin
        if (mem_resp_valid) begin
          arr_we           = 1'b1;
          arr_idx          = addr_q[IDX_W+1:2];
          arr_tag          = addr_q[AW-1:IDX_W+2];
          arr_data         = mem_resp_data;
          valid_d[arr_idx] = 1'b1;
          resp_valid_d     = 1'b1;
          resp_data_d      = extract(mem_resp_data, addr_q[1:0], ld_size_q);
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      ld_size_q    <= 3'd0;
      wdata_q      <= 32'h0;
      mask_q       <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      misalign_q   <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      ld_size_q    <= ld_size_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      misalign_q   <= misalign_d;
      valid_q      <= valid_d;
    end
  end

  // Line storage needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_q[arr_idx] <= arr_data;
      tag_q[arr_idx]  <= arr_tag;
    end
  end

  assign stall         = (state_q != IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign misalign      = misalign_q;
  assign mem_req_valid = (state_q == WRITE) || (state_q == READ_REQ);
  assign mem_req_we    = (state_q == WRITE);
  assign mem_req_addr  = mem_req_valid ? {addr_q[AW-1:2], 2'b00} : '0;
  assign mem_req_wdata = mem_req_we ? wdata_q : 32'h0;
  assign mem_req_mask  = mem_req_we ? mask_q : 4'h0;
  assign dbg_state     = state_q;

`ifdef DCACHE_STATS_EN
  logic        load_acc;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    load_acc     = (state_q == IDLE) && req_valid && !req_we && !misaligned;
    hit_count_d  = hit_count_q + {31'b0, load_acc && hit};
    miss_count_d = miss_count_q + {31'b0, load_acc && !hit};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: vector table for single-cycle hit/misalign cases plus
// hand-written miss, write-through, no-allocate and reset-abandon sequences.
module tb_dcache_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_st_size;
  logic [2:0]  req_ld_size;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        misalign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [1:0]  dbg_state;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_responder #(.LINES(64), .AW(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_st_size   (req_st_size),
    .req_ld_size   (req_ld_size),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .misalign      (misalign),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_mask  (mem_req_mask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
`ifdef DCACHE_STATS_EN
    .hit_count     (hit_count),
    .miss_count    (miss_count),
`endif
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  st_size;
    logic [2:0]  ld_size;
    logic        exp_rv;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] st, input logic [2:0] ld, input logic rv,
                         input logic [31:0] data, input logic mis);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.st_size = st; v.ld_size = ld;
    v.exp_rv = rv; v.exp_data = data; v.exp_mis = mis;
    vecs.push_back(v);
  endtask

  // Driver: a single-cycle request whose effect is fully visible on the next cycle.
  task automatic apply_vec(input vec_t v, input string tag);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_st_size = v.st_size; req_ld_size = v.ld_size;
    if (v.exp_rv) exp_q.push_back(v.exp_data);
    tick();
    req_valid = 1'b0;
    check({tag, "_resp_valid"}, resp_valid, v.exp_rv);
    check({tag, "_misalign"}, misalign, v.exp_mis);
    check({tag, "_stall"}, stall, 1'b0);
    check({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    check({tag, "_state"}, dbg_state, 2'd0);
    if (resp_valid) begin
      if (exp_q.size() == 0) check({tag, "_unexpected_resp"}, 1'b1, 1'b0);
      else check({tag, "_resp_data"}, resp_data, exp_q.pop_front());
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    tick();
    check({tag, "_resp_pulse_end"}, resp_valid, 1'b0);
    check({tag, "_misalign_pulse_end"}, misalign, 1'b0);
  endtask

  // Load miss: grant at the first request cycle, return data 3 cycles after the grant.
  task automatic load_miss(input string tag, input logic [31:0] addr, input logic [2:0] ld,
                           input logic [31:0] mdata, input logic [31:0] exp);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_ld_size = ld;
    req_st_size = 2'd0; req_wdata = 32'h0;
    tick();
    check({tag, "_stall_n1"}, stall, 1'b1);
    check({tag, "_mreq_valid"}, mem_req_valid, 1'b1);
    check({tag, "_mreq_we"}, mem_req_we, 1'b0);
    check({tag, "_mreq_addr"}, mem_req_addr, {addr[31:2], 2'b00});
    check({tag, "_no_early_resp"}, resp_valid, 1'b0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check({tag, "_mreq_dropped"}, mem_req_valid, 1'b0);
    check({tag, "_stall_n2"}, stall, 1'b1);
    tick();
    tick();
    check({tag, "_stall_n4"}, stall, 1'b1);
    mem_resp_valid = 1'b1; mem_resp_data = mdata;
    tick();
    mem_resp_valid = 1'b0; req_valid = 1'b0;
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_resp_data"}, resp_data, exp);
    check({tag, "_stall_end"}, stall, 1'b0);
    tick();
    check({tag, "_resp_pulse_end"}, resp_valid, 1'b0);
  endtask

  // Write-through with mem_req_ready held low for 'delay' cycles before the grant.
  task automatic store_wt(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] st, input int delay, input logic [3:0] exp_mask,
                          input logic [31:0] exp_wdata);
    int stall_cnt;
    stall_cnt = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = wdata;
    req_st_size = st; req_ld_size = 3'd2;
    tick();
    for (int c = 0; c <= delay; c++) begin
      if (stall) stall_cnt++;
      check($sformatf("%s_c%0d_mreq_valid", tag, c), mem_req_valid, 1'b1);
      check($sformatf("%s_c%0d_mreq_we", tag, c), mem_req_we, 1'b1);
      check($sformatf("%s_c%0d_mreq_addr", tag, c), mem_req_addr, {addr[31:2], 2'b00});
      check($sformatf("%s_c%0d_mreq_mask", tag, c), mem_req_mask, exp_mask);
      check($sformatf("%s_c%0d_mreq_wdata", tag, c), mem_req_wdata, exp_wdata);
      mem_req_ready = (c == delay);
      tick();
    end
    mem_req_ready = 1'b0; req_valid = 1'b0;
    check({tag, "_stall_cycles"}, stall_cnt, delay + 1);
    check({tag, "_stall_end"}, stall, 1'b0);
    check({tag, "_mreq_end"}, mem_req_valid, 1'b0);
    check({tag, "_no_resp"}, resp_valid, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall, 1'b0);
    check({tag, "_resp_valid"}, resp_valid, 1'b0);
    check({tag, "_resp_data"}, resp_data, 32'h0);
    check({tag, "_misalign"}, misalign, 1'b0);
    check({tag, "_mreq_valid"}, mem_req_valid, 1'b0);
    check({tag, "_mreq_we"}, mem_req_we, 1'b0);
    check({tag, "_mreq_addr"}, mem_req_addr, 32'h0);
    check({tag, "_mreq_wdata"}, mem_req_wdata, 32'h0);
    check({tag, "_mreq_mask"}, mem_req_mask, 4'h0);
  endtask

  task automatic lw(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    vec_t v;
    v.we = 1'b0; v.addr = addr; v.wdata = 32'h0; v.st_size = 2'd0; v.ld_size = 3'd2;
    v.exp_rv = 1'b1; v.exp_data = exp; v.exp_mis = 1'b0;
    apply_vec(v, tag);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_st_size = 2'd0; req_ld_size = 3'd0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = 32'h0;

    // Hits after the 0xDEADBEEF fill at 0x100, then misaligned requests.
    add_vec(1'b0, 32'h100, 32'h0, 2'd0, 3'd2, 1'b1, 32'hDEADBEEF, 1'b0);
    add_vec(1'b0, 32'h103, 32'h0, 2'd0, 3'd0, 1'b1, 32'hFFFFFFDE, 1'b0);
    add_vec(1'b0, 32'h103, 32'h0, 2'd0, 3'd4, 1'b1, 32'h000000DE, 1'b0);
    add_vec(1'b0, 32'h102, 32'h0, 2'd0, 3'd1, 1'b1, 32'hFFFFDEAD, 1'b0);
    add_vec(1'b0, 32'h100, 32'h0, 2'd0, 3'd5, 1'b1, 32'h0000BEEF, 1'b0);
    add_vec(1'b0, 32'h101, 32'h0, 2'd0, 3'd0, 1'b1, 32'hFFFFFFBE, 1'b0);
    add_vec(1'b0, 32'h102, 32'h0, 2'd0, 3'd4, 1'b1, 32'h000000AD, 1'b0);
    add_vec(1'b0, 32'h100, 32'h0, 2'd0, 3'd1, 1'b1, 32'hFFFFBEEF, 1'b0);
    add_vec(1'b0, 32'h100, 32'h0, 2'd0, 3'd0, 1'b1, 32'hFFFFFFEF, 1'b0);
    add_vec(1'b0, 32'h100, 32'h0, 2'd0, 3'd3, 1'b1, 32'hDEADBEEF, 1'b0);
    add_vec(1'b1, 32'h201, 32'h1234, 2'd1, 3'd0, 1'b0, 32'h0, 1'b1);
    add_vec(1'b0, 32'h102, 32'h0, 2'd0, 3'd2, 1'b1, 32'h0, 1'b1);
    add_vec(1'b0, 32'h103, 32'h0, 2'd0, 3'd1, 1'b1, 32'h0, 1'b1);
    add_vec(1'b0, 32'h101, 32'h0, 2'd0, 3'd5, 1'b1, 32'h0, 1'b1);
    add_vec(1'b1, 32'h102, 32'hFFFFFFFF, 2'd2, 3'd0, 1'b0, 32'h0, 1'b1);

    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    check_all_zero("post_reset");

    load_miss("miss_100", 32'h100, 3'd2, 32'hDEADBEEF, 32'hDEADBEEF);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    store_wt("sb_101", 32'h101, 32'h0000005A, 2'd0, 4, 4'b0010, 32'h5A5A5A5A);
    lw("lw_after_sb", 32'h100, 32'hDEAD5AEF);
    store_wt("sh_102", 32'h102, 32'hABCD1234, 2'd1, 0, 4'b1100, 32'h12341234);
    lw("lw_after_sh", 32'h100, 32'h12345AEF);
    // Same index, different tag: a store miss must leave the resident line untouched.
    store_wt("sw_400", 32'h400, 32'h11112222, 2'd2, 0, 4'hF, 32'h11112222);
    lw("lw_no_alloc", 32'h100, 32'h12345AEF);

    // Reset while waiting for fill data, then a stale response.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400; req_ld_size = 3'd2;
    tick();
    req_valid = 1'b0;
    check("abandon_miss_400", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("abandon_in_read_wait", dbg_state, 2'd3);
    tick();
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    check("mid_reset_state", dbg_state, 2'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
    tick();
    mem_resp_valid = 1'b0;
    check("stale_resp_ignored", resp_valid, 1'b0);
    check("stale_resp_stall", stall, 1'b0);
    check("stale_resp_state", dbg_state, 2'd0);
    load_miss("miss_after_reset", 32'h100, 3'd2, 32'hCAFEF00D, 32'hCAFEF00D);

`ifdef DCACHE_STATS_EN
    reset = 1'b0;
    tick();
    check("stats_reset_hits", hit_count, 32'd0);
    check("stats_reset_misses", miss_count, 32'd0);
    reset = 1'b1;
    tick();
    load_miss("stats_miss_300", 32'h300, 3'd2, 32'h0BADF00D, 32'h0BADF00D);
    lw("stats_hit1", 32'h300, 32'h0BADF00D);
    lw("stats_hit2", 32'h300, 32'h0BADF00D);
    store_wt("stats_sw_300", 32'h300, 32'h55667788, 2'd2, 0, 4'hF, 32'h55667788);
    check("stats_hit_count", hit_count, 32'd2);
    check("stats_miss_count", miss_count, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
